// File: rtl/jtag_scan_master.sv
// jtag_scan_master: JTAG host that turns clk-side commands into
// TAP reset, IR/DR scan and run-idle TCK/TMS/TDI sequences.
module jtag_scan_master #(
    parameter int IR_LEN    = 5,
    parameter int DR_MAX    = 40,
    parameter int LEN_W     = 6,
    parameter int CLK_DIV   = 2,
    parameter int RST_TCKS  = 8,
    parameter int IDLE_TCKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              jtag_TCK,
    output logic              jtag_TMS,
    output logic              jtag_TDI,
    input  logic              jtag_TDO
);

    localparam logic [1:0] T_RST = 2'b00;
    localparam logic [1:0] T_IR  = 2'b01;
    localparam logic [1:0] T_DR  = 2'b10;
    localparam logic [1:0] T_RUN = 2'b11;

    localparam int CNT_W = 16;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE, PRE, SHIFT, POST, RUN, DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        typ_q, typ_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  slot_q, slot_d;
    logic [CNT_W-1:0]  slots_here;
    logic [CNT_W-1:0]  pre_cnt;
    logic [DIV_W-1:0]  div_q;
    logic [DR_MAX-1:0] sh_q;
    logic              tap_synced;

    logic accept, bad;
    logic phase_end, slot_end, last_slot;
    logic new_slot, tms_d;

    assign cmd_ready = (state_q == IDLE) && !rsp_valid;
    assign accept    = cmd_valid && cmd_ready;
    assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
    assign slot_end  = jtag_TCK && phase_end;

    // Command validity and the fields latched on accept
    always_comb begin
        bad   = 1'b0;
        typ_d = typ_q;
        len_d = len_q;
        run_d = run_q;
        unique case (cmd_type)
            T_RST: bad = 1'b0;
            T_IR:  bad = !tap_synced;
            T_DR:  bad = !tap_synced || (cmd_len == '0) ||
                         (cmd_len > LEN_W'(DR_MAX));
            T_RUN: bad = !tap_synced || (cmd_len == '0);
        endcase
        if (accept) begin
            typ_d = cmd_type;
            len_d = (cmd_type == T_IR) ? CNT_W'(IR_LEN)
                                       : CNT_W'(cmd_len);
            unique case (cmd_type)
                T_RST:   run_d = CNT_W'(1);
                T_RUN:   run_d = CNT_W'(cmd_len);
                default: run_d = CNT_W'(IDLE_TCKS);
            endcase
        end
    end

    // Number of TCK slots spent in the current state
    always_comb begin
        pre_cnt = (typ_q == T_RST) ? CNT_W'(RST_TCKS) :
                  (typ_q == T_IR)  ? CNT_W'(4) : CNT_W'(3);
        unique case (state_q)
            PRE:     slots_here = pre_cnt;
            SHIFT:   slots_here = len_q;
            POST:    slots_here = CNT_W'(2);
            RUN:     slots_here = run_q;
            default: slots_here = CNT_W'(1);
        endcase
        last_slot = (slot_q + CNT_W'(1) == slots_here);
    end

    // Next state, slot index and TMS for the slot being started
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        new_slot = 1'b0;
        tms_d    = jtag_TMS;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    slot_d = '0;
                    if (bad) begin
                        state_d = DONE;
                    end else begin
                        new_slot = 1'b1;
                        state_d  = (cmd_type == T_RUN) ? RUN : PRE;
                    end
                end
            end
            PRE, SHIFT, POST, RUN: begin
                if (slot_end) begin
                    if (!last_slot) begin
                        slot_d   = slot_q + CNT_W'(1);
                        new_slot = 1'b1;
                    end else begin
                        slot_d = '0;
                        unique case (state_q)
                            PRE:
                                state_d = (typ_q == T_RST) ? RUN
                                                           : SHIFT;
                            SHIFT:
                                state_d = POST;
                            POST:
                                state_d = (run_q != '0) ? RUN : DONE;
                            default:
                                state_d = DONE;
                        endcase
                        new_slot = (state_d != DONE);
                    end
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (new_slot) begin
            unique case (state_d)
                PRE:
                    tms_d = (typ_d == T_RST) ||
                            (slot_d < ((typ_d == T_IR) ? CNT_W'(2)
                                                       : CNT_W'(1)));
                SHIFT:
                    tms_d = (slot_d + CNT_W'(1) == len_d);
                POST:
                    tms_d = (slot_d == '0);
                default:
                    tms_d = 1'b0;
            endcase
        end
    end

    // State, TCK divider, pin drive, capture and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            typ_q      <= T_RST;
            len_q      <= '0;
            run_q      <= '0;
            div_q      <= '0;
            sh_q       <= '0;
            tap_synced <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            jtag_TCK   <= 1'b0;
            jtag_TMS   <= 1'b1;
            jtag_TDI   <= 1'b1;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            typ_q   <= typ_d;
            len_q   <= len_d;
            run_q   <= run_d;
            busy    <= (state_d != IDLE) && (state_d != DONE);
            if (accept) begin
                sh_q     <= cmd_data;
                rsp_data <= '0;
                rsp_err  <= bad;
            end
            if (new_slot) begin
                jtag_TMS <= tms_d;
                jtag_TDI <= 1'b1;
                if (state_d == SHIFT) begin
                    jtag_TDI <= sh_q[0];
                    sh_q     <= sh_q >> 1;
                end
            end
            if (busy) begin
                if (phase_end) begin
                    div_q    <= '0;
                    jtag_TCK <= !jtag_TCK;
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
                if (phase_end && !jtag_TCK && state_q == SHIFT)
                    rsp_data[slot_q[IDX_W-1:0]] <= jtag_TDO;
            end
            if (state_d == DONE && state_q != DONE) begin
                rsp_valid <= 1'b1;
                if (typ_d == T_RST) tap_synced <= 1'b1;
            end else if (state_q == DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: drives jtag_scan_master against a behavioural
// TAP model; table vectors, random commands and corner sequences.
module tb_jtag_scan_master;

    localparam int IR_LEN    = 5;
    localparam int DR_MAX    = 40;
    localparam int LEN_W     = 6;
    localparam int CLK_DIV   = 2;
    localparam int RST_TCKS  = 8;
    localparam int IDLE_TCKS = 1;
    localparam logic [39:0] CAPT    = 40'hA5_1234_5678;
    localparam logic [4:0]  IR_CAPT = 5'b00001;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_type = 2'b00;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DR_MAX-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DR_MAX-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              jtag_TCK, jtag_TMS, jtag_TDI;
    logic              tdo_r = 1'b0;

    always #5 clk = ~clk;

    jtag_scan_master #(
        .IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .LEN_W(LEN_W),
        .CLK_DIV(CLK_DIV), .RST_TCKS(RST_TCKS), .IDLE_TCKS(IDLE_TCKS)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS),
        .jtag_TDI(jtag_TDI), .jtag_TDO(tdo_r)
    );

    // IEEE 1149.1 TAP controller model
    typedef enum int {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR
    } tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:     return tms ? TLR   : RTI;
            RTI:     return tms ? SELDR : RTI;
            SELDR:   return tms ? SELIR : CAPDR;
            CAPDR:   return tms ? EX1DR : SHDR;
            SHDR:    return tms ? EX1DR : SHDR;
            EX1DR:   return tms ? UPDR  : PSDR;
            PSDR:    return tms ? EX2DR : PSDR;
            EX2DR:   return tms ? UPDR  : SHDR;
            UPDR:    return tms ? SELDR : RTI;
            SELIR:   return tms ? TLR   : CAPIR;
            CAPIR:   return tms ? EX1IR : SHIR;
            SHIR:    return tms ? EX1IR : SHIR;
            EX1IR:   return tms ? UPIR  : PSIR;
            PSIR:    return tms ? EX2IR : PSIR;
            EX2IR:   return tms ? UPIR  : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    tap_t        tap_st = SHDR;
    logic [4:0]  ir_sr = '0, ir_q = '0;
    logic [39:0] dr_sr = '0, dr_upd = '0;
    int          rises = 0;
    logic        tms_hist[$];
    logic        tdi_hist[$];
    time         t_hist[$];

    // TAP model clocked by TCK; also logs every rising edge
    always @(posedge jtag_TCK) begin
        tms_hist.push_back(jtag_TMS);
        tdi_hist.push_back(jtag_TDI);
        t_hist.push_back($time);
        rises = rises + 1;
        case (tap_st)
            CAPIR:   ir_sr = IR_CAPT;
            SHIR:    ir_sr = {jtag_TDI, ir_sr[IR_LEN-1:1]};
            UPIR:    ir_q = ir_sr;
            CAPDR:   dr_sr = CAPT;
            SHDR:    dr_sr = {jtag_TDI, dr_sr[DR_MAX-1:1]};
            UPDR:    dr_upd = dr_sr;
            default: ;
        endcase
        tap_st = tap_next(tap_st, jtag_TMS);
    end

    // TDO changes on the falling TCK edge
    always @(negedge jtag_TCK) begin
        tdo_r = (tap_st == SHIR) ? ir_sr[0] :
                (tap_st == SHDR) ? dr_sr[0] : 1'b0;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    logic        model_synced = 1'b0;
    logic [39:0] r_data;
    logic        r_err, r_rv1, r_bz1, r_rdy_after, r_tck_after;
    int          r_base, r_nr;

    // Expected TMS/TDI per slot, built from the command's slot rules
    task automatic build_exp(input logic [1:0] t, input int len,
                             input logic [39:0] d,
                             output logic [127:0] et,
                             output logic [127:0] ed);
        int n, npre, nsh;
        et = '0;
        ed = '0;
        n = 0;
        if (t == 2'd0) begin
            for (int i = 0; i < RST_TCKS; i++) begin
                et[n] = 1'b1; ed[n] = 1'b1; n = n + 1;
            end
            ed[n] = 1'b1; n = n + 1;
        end else if (t == 2'd3) begin
            for (int i = 0; i < len; i++) begin
                ed[n] = 1'b1; n = n + 1;
            end
        end else begin
            npre = (t == 2'd1) ? 4 : 3;
            nsh  = (t == 2'd1) ? IR_LEN : len;
            for (int i = 0; i < npre; i++) begin
                et[n] = (i < npre - 2); ed[n] = 1'b1; n = n + 1;
            end
            for (int i = 0; i < nsh; i++) begin
                et[n] = (i == nsh - 1); ed[n] = d[i]; n = n + 1;
            end
            et[n] = 1'b1; ed[n] = 1'b1; n = n + 1;
            et[n] = 1'b0; ed[n] = 1'b1; n = n + 1;
            for (int i = 0; i < IDLE_TCKS; i++) begin
                ed[n] = 1'b1; n = n + 1;
            end
        end
    endtask

    task automatic model_exp(input logic [1:0] t, input int len,
                             output logic e, output logic [39:0] dat,
                             output int nr);
        logic [63:0] m;
        m = (64'd1 << len) - 64'd1;
        e = (t != 2'd0 && !model_synced) ||
            ((t == 2'd2 || t == 2'd3) && len == 0) ||
            (t == 2'd2 && len > DR_MAX);
        dat = '0;
        nr = 0;
        if (!e) begin
            case (t)
                2'd0: nr = RST_TCKS + 1;
                2'd1: begin
                    nr = 4 + IR_LEN + 2 + IDLE_TCKS;
                    dat = 40'(IR_CAPT);
                end
                2'd2: begin
                    nr = 3 + len + 2 + IDLE_TCKS;
                    dat = CAPT & m[39:0];
                end
                default: nr = len;
            endcase
        end
    endtask

    task automatic issue(input logic [1:0] t, input int len,
                         input logic [39:0] d);
        int w;
        cmd_type = t;
        cmd_len = LEN_W'(len);
        cmd_data = d;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w = w + 1;
        end
        if (!cmd_ready) chk("cmd_ready wait", 128'(cmd_ready), 128'(1));
        r_base = rises;
        @(negedge clk);
        cmd_valid = 1'b0;
        r_rv1 = rsp_valid;
        r_bz1 = busy;
    endtask

    task automatic wait_rsp();
        int w;
        w = 0;
        while (!rsp_valid && w < 4000) begin
            @(negedge clk);
            w = w + 1;
        end
        if (!rsp_valid) chk("rsp_valid wait", 128'(rsp_valid), 128'(1));
        r_data = rsp_data;
        r_err = rsp_err;
        r_nr = rises - r_base;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        r_rdy_after = cmd_ready;
        r_tck_after = jtag_TCK;
    endtask

    task automatic verify(input string nm, input logic [1:0] t,
                          input int len, input logic [39:0] d,
                          input logic e_err, input logic [39:0] e_dat,
                          input int e_nr);
        logic [127:0] et, ed, at, ad;
        logic [63:0]  m;
        int bad_per;
        issue(t, len, d);
        if (e_err) chk({nm, " rsp next cycle"}, 128'(r_rv1), 128'(1));
        else chk({nm, " busy after accept"}, 128'(r_bz1), 128'(1));
        wait_rsp();
        chk({nm, " err"}, 128'(r_err), 128'(e_err));
        chk({nm, " data"}, 128'(r_data), 128'(e_dat));
        chk({nm, " tck rises"}, 128'(r_nr), 128'(e_nr));
        chk({nm, " ready/tck after"},
            128'({r_rdy_after, r_tck_after}), 128'(2'b10));
        if (!e_err) begin
            build_exp(t, len, d, et, ed);
            at = '0;
            ad = '0;
            for (int i = 0; i < r_nr && i < 128; i++) begin
                at[i] = tms_hist[r_base + i];
                ad[i] = tdi_hist[r_base + i];
            end
            chk({nm, " tms seq"}, at, et);
            chk({nm, " tdi seq"}, ad, ed);
            bad_per = 0;
            for (int i = r_base + 1; i < r_base + r_nr; i++)
                if (t_hist[i] - t_hist[i-1] != 2 * CLK_DIV * 10)
                    bad_per = bad_per + 1;
            chk({nm, " tck period"}, 128'(bad_per), 128'(0));
            chk({nm, " tap in idle"}, 128'(tap_st), 128'(RTI));
            if (t == 2'd1) chk({nm, " tap ir"}, 128'(ir_q), 128'(d[4:0]));
            if (t == 2'd2) begin
                m = (64'd1 << len) - 64'd1;
                chk({nm, " tap dr"},
                    128'(64'(dr_upd) >> (DR_MAX - len)),
                    128'(64'(d) & m));
            end
            if (t == 2'd0) model_synced = 1'b1;
        end
    endtask

    typedef struct {
        logic [1:0]  t;
        int          len;
        logic [39:0] d;
        logic        err;
        logic [39:0] dat;
        int          nr;
        string       nm;
    } vec_t;

    vec_t        tbl[11];
    logic [1:0]  rt;
    int          rlen, w, r0, seen;
    logic [39:0] rd, held;
    logic        re, stable;
    int          rnr;

    initial begin
        tbl[0]  = '{2'd1, 0,  40'h11, 1'b1, 40'h0, 0, "ir unsynced"};
        tbl[1]  = '{2'd0, 0,  40'h0,  1'b0, 40'h0, 9, "tap reset"};
        tbl[2]  = '{2'd1, 0,  40'h11, 1'b0, 40'h01, 12, "ir 0x11"};
        tbl[3]  = '{2'd2, 40, 40'h10_0000_0002, 1'b0,
                    40'hA5_1234_5678, 46, "dr 40"};
        tbl[4]  = '{2'd2, 0,  40'h5,  1'b1, 40'h0, 0, "dr len0"};
        tbl[5]  = '{2'd2, 41, 40'h5,  1'b1, 40'h0, 0, "dr len41"};
        tbl[6]  = '{2'd3, 5,  40'h0,  1'b0, 40'h0, 5, "run 5"};
        tbl[7]  = '{2'd3, 0,  40'h0,  1'b1, 40'h0, 0, "run 0"};
        tbl[8]  = '{2'd2, 1,  40'h1,  1'b0, 40'h0, 7, "dr len1"};
        tbl[9]  = '{2'd2, 8,  40'h3C, 1'b0, 40'h78, 14, "dr len8"};
        tbl[10] = '{2'd1, 3,  40'h1F, 1'b0, 40'h01, 12, "ir 0x1f"};

        repeat (3) @(negedge clk);
        chk("reset pins",
            128'({cmd_ready, rsp_valid, rsp_err, busy,
                  jtag_TCK, jtag_TMS, jtag_TDI}),
            128'(7'b1000011));
        chk("reset rsp_data", 128'(rsp_data), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle pins",
            128'({cmd_ready, busy, jtag_TCK, jtag_TMS}),
            128'(4'b1001));

        for (int i = 0; i < 11; i++)
            verify(tbl[i].nm, tbl[i].t, tbl[i].len, tbl[i].d,
                   tbl[i].err, tbl[i].dat, tbl[i].nr);

        for (int i = 0; i < 40; i++) begin
            rt = 2'($urandom_range(1, 3));
            if (i % 13 == 7) rt = 2'd0;
            rlen = (rt == 2'd2) ? int'($urandom_range(0, 44))
                                : int'($urandom_range(0, 10));
            rd = {8'($urandom), 32'($urandom)};
            model_exp(rt, rlen, re, held, rnr);
            verify("rand", rt, rlen, rd, re, held, rnr);
        end

        // Response held off: no new command until after the transfer
        issue(2'd2, 16, 40'h1_2345);
        w = 0;
        while (!rsp_valid && w < 1000) begin
            @(negedge clk);
            w = w + 1;
        end
        held = rsp_data;
        chk("hold data", 128'(held), 128'(40'h5678));
        cmd_type = 2'd3;
        cmd_len = LEN_W'(3);
        cmd_data = '0;
        cmd_valid = 1'b1;
        r0 = rises;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== held || cmd_ready || busy)
                stable = 1'b0;
        end
        chk("hold stable", 128'(stable), 128'(1));
        chk("hold no tck", 128'(rises - r0), 128'(0));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("ready after xfer",
            128'({cmd_ready, rsp_valid, busy}), 128'(3'b100));
        r_base = rises;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("accept after xfer", 128'(busy), 128'(1));
        wait_rsp();
        chk("queued run rises", 128'(r_nr), 128'(3));
        chk("queued run err", 128'(r_err), 128'(0));

        // Reset pulse in the middle of a DR shift
        issue(2'd2, 40, 40'hFF_FFFF_FFFF);
        w = 0;
        while ((rises - r_base) < 10 && w < 500) begin
            @(negedge clk);
            w = w + 1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_synced = 1'b0;
        chk("abort pins",
            128'({jtag_TCK, jtag_TMS, jtag_TDI, busy,
                  rsp_valid, cmd_ready}),
            128'(6'b011001));
        r0 = rises;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen = seen + 1;
        end
        chk("abort no rsp", 128'(seen), 128'(0));
        chk("abort no tck", 128'(rises - r0), 128'(0));
        verify("ir after abort", 2'd1, 0, 40'h11, 1'b1, 40'h0, 0);
        verify("resync", 2'd0, 0, 40'h0, 1'b0, 40'h0, 9);
        verify("ir resynced", 2'd1, 0, 40'h0A, 1'b0, 40'h01, 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Synthesizable JTAG host that drives an external or internal TAP through parametrised IR/DR scans, run-idle and TAP-reset sequences.
- Replaces hand-written TCK/TMS bit-banging in benches, and serves as an on-chip debug bridge master in the SoC.
- Command/response handshake on the clk side. TCK is derived from clk by a programmable divider.

Parameters:
- IR_LEN, 5, instruction register length in bits (1..DR_MAX).
- DR_MAX, 40, maximum DR scan length and command/response data width.
- LEN_W, 6, width of cmd_len; must satisfy 2^LEN_W > DR_MAX.
- CLK_DIV, 2, clk cycles per TCK half-period (>=1).
- RST_TCKS, 8, TCK cycles with TMS=1 in a reset command.
- IDLE_TCKS, 1, extra Run-Test/Idle TCK cycles appended after every IR/DR scan.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_type  in  2  00 TAP reset, 01 IR scan, 10 DR scan, 11 run-idle
- cmd_len  in  LEN_W  DR scan length or run-idle TCK count; ignored for reset and IR
- cmd_data  in  DR_MAX  bits shifted into TDI, LSB first
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  DR_MAX  bits captured from TDO, first captured bit at bit0, zero above length
- rsp_err  out  1  command rejected
- busy  out  1  sequence in progress
- jtag_TCK  out  1  test clock
- jtag_TMS  out  1  test mode select
- jtag_TDI  out  1  test data in
- jtag_TDO  in  1  test data out

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, jtag_TCK=0, jtag_TMS=1, jtag_TDI=1. Internal tap_synced=0.
- Handshake:
  - Command accepted on a clk edge with cmd_valid&&cmd_ready. Command fields are latched on that edge.
  - cmd_ready=1 only in IDLE with rsp_valid=0.
  - rsp_valid holds with stable rsp_data/rsp_err until rsp_valid&&rsp_ready. cmd_ready rises the cycle after that transfer.
- TCK slot: one TCK period = 2*CLK_DIV clk cycles.
  - Low phase first: TMS/TDI are updated on the clk edge that drives TCK low.
  - High phase follows: TCK rises after CLK_DIV cycles.
  - TDO is registered on the clk edge that drives TCK high.
  - Between commands, TCK stays low.
- States: IDLE, PRE, SHIFT, POST, RUN, DONE.
- Per-command TMS sequence:
  - Reset: RST_TCKS slots TMS=1, then 1 slot TMS=0 (Idle). Sets tap_synced=1.
  - IR scan: PRE TMS 1,1,0,0 (SelDR, SelIR, CaptureIR, ShiftIR). SHIFT: IR_LEN slots, TDI=cmd_data[k], last slot TMS=1 (Exit1). POST TMS 1,0 (Update, Idle). RUN: IDLE_TCKS slots TMS=0.
  - DR scan: PRE TMS 1,0,0. SHIFT: cmd_len slots as for IR. POST 1,0. RUN: IDLE_TCKS.
  - Run-idle: cmd_len slots TMS=0.
  - Slot counts:
    - reset: RST_TCKS+1
    - IR: 4+IR_LEN+2+IDLE_TCKS
    - DR: 3+cmd_len+2+IDLE_TCKS
    - run-idle: cmd_len
- DONE: on the clk edge ending the last high phase, TCK goes low, rsp_valid=1, busy=0.
- TDI outside SHIFT is 1.
- Capture: bit k of rsp_data is the TDO sampled in shift slot k. For IR, bits >= IR_LEN are 0. For run-idle and reset, rsp_data=0.
- Errors: rsp_err=1, rsp_data=0, no TCK activity, rsp_valid the cycle after accept, in any of these cases:
  - DR or run-idle with cmd_len==0;
  - DR with cmd_len>DR_MAX;
  - IR/DR/run-idle while tap_synced=0.
- busy=1 from the cycle after accept until DONE.
- rst mid-sequence: all state and outputs return to reset values next edge and tap_synced=0. The aborted command produces no response.
- rst takes priority over every other event.

Test Plan:
- Reset command, CLK_DIV=2: exactly 9 TCK rising edges, TMS=1 for 8 then 0, each TCK period 4 clk. rsp_valid with rsp_err=0, rsp_data=0.
- After reset, IR scan with cmd_data=0x11 against a bench TAP model: model IR=0x11, TMS sequence 1,1,0,0,0,0,0,0,1,1,0,0. rsp_data=0x01 (IR capture pattern).
- DR scan len 40, cmd_data=0x10_0000_0002, TDO looped through a 40-bit model shift register preloaded with 0xA5_1234_5678: rsp_data=0xA5_1234_5678, total 3+40+2+1=46 TCK rises.
- Errors:
  - DR len 0 -> rsp_err=1, no TCK edge.
  - DR len 41 -> rsp_err=1, no TCK edge.
  - IR scan issued before any reset command -> rsp_err=1, no TCK edge.
- Hold rsp_ready=0 for 20 cycles after a DR scan: rsp_valid/rsp_data stable, cmd_ready=0, a new cmd_valid is not accepted until the cycle after rsp_ready.
- Assert rst for 1 cycle mid-SHIFT of a DR scan: next cycle TCK=0, TMS=1, TDI=1, busy=0, no rsp_valid. A subsequent IR scan returns rsp_err=1.
